// File: rtl/spio_hss_multiplexer_link_supervisor_pkg.sv
// Shared definitions for the HSS link supervisor: state encodings and the
// backoff exponent cap used when a bring-up attempt fails.
package spio_hss_multiplexer_link_supervisor_pkg;

   // The encodings are visible on STATE_OUT, so they are fixed values.
   typedef enum logic [2:0] {
      LSUP_XRESET    = 3'd0,
      LSUP_WAIT_DONE = 3'd1,
      LSUP_WAIT_SYNC = 3'd2,
      LSUP_HANDSHAKE = 3'd3,
      LSUP_UP        = 3'd4,
      LSUP_BACKOFF   = 3'd5
   } lsup_state_t;

   // Largest left shift applied to the backoff base after repeated failures.
   localparam int MAX_BACKOFF_EXP = 6;

endpackage

// File: rtl/spio_hss_multiplexer_link_supervisor_if.sv
// Signal bundle between the link supervisor, the transceiver wrapper and
// rx_control/tx_control. Stats signals exist only when
// SPIO_HSS_LINK_SUPERVISOR_STATS_EN is defined.
//
// Signalling contract: there is no valid/ready pairing on this bundle. Every
// signal is a level, sampled on each rising CLK_IN edge; *_IN levels are
// owned by the slave side and *_OUT levels by the supervisor (master), and
// each *_OUT is a register that changes only on a clock edge or on reset.
interface spio_hss_multiplexer_link_supervisor_if;

   logic        XCVR_RESETDONE_IN;
   logic [1:0]  RXLOSSOFSYNC_IN;
   logic        HANDSHAKE_COMPLETE_IN;
   logic        VERSION_MISMATCH_IN;
   logic        XCVR_RXRESET_OUT;
   logic        CTRL_RESET_OUT;
   logic        LINK_UP_OUT;
   logic [2:0]  STATE_OUT;
   logic [3:0]  RETRY_COUNT_OUT;
   logic        VERSION_ERROR_OUT;
`ifdef SPIO_HSS_LINK_SUPERVISOR_STATS_EN
   logic        STATS_CLR_IN;
   logic [15:0] LINK_DROPS_OUT;
   logic [15:0] TIMEOUTS_OUT;
`endif

   modport master (
      input  XCVR_RESETDONE_IN,
      input  RXLOSSOFSYNC_IN,
      input  HANDSHAKE_COMPLETE_IN,
      input  VERSION_MISMATCH_IN,
`ifdef SPIO_HSS_LINK_SUPERVISOR_STATS_EN
      input  STATS_CLR_IN,
      output LINK_DROPS_OUT,
      output TIMEOUTS_OUT,
`endif
      output XCVR_RXRESET_OUT,
      output CTRL_RESET_OUT,
      output LINK_UP_OUT,
      output STATE_OUT,
      output RETRY_COUNT_OUT,
      output VERSION_ERROR_OUT
   );

   modport slave (
      output XCVR_RESETDONE_IN,
      output RXLOSSOFSYNC_IN,
      output HANDSHAKE_COMPLETE_IN,
      output VERSION_MISMATCH_IN,
`ifdef SPIO_HSS_LINK_SUPERVISOR_STATS_EN
      output STATS_CLR_IN,
      input  LINK_DROPS_OUT,
      input  TIMEOUTS_OUT,
`endif
      input  XCVR_RXRESET_OUT,
      input  CTRL_RESET_OUT,
      input  LINK_UP_OUT,
      input  STATE_OUT,
      input  RETRY_COUNT_OUT,
      input  VERSION_ERROR_OUT
   );

endinterface

// File: rtl/spio_hss_multiplexer_link_supervisor_timer.sv
// Loadable down-counter shared by every supervisor state. It stops at zero
// instead of wrapping and reports zero through a flag.
module spio_hss_multiplexer_link_supervisor_timer #(
   parameter int                    TIMER_BITS = 24,
   parameter logic [TIMER_BITS-1:0] INIT_VAL   = '0
) (
   input  logic                  CLK_IN,
   input  logic                  RESET_IN,
   input  logic                  load,
   input  logic [TIMER_BITS-1:0] load_val,
   output logic                  zero
);

   logic [TIMER_BITS-1:0] count;

   // Load wins over counting; otherwise count down and hold at zero.
   always_ff @(posedge CLK_IN or negedge RESET_IN) begin
      if (!RESET_IN) begin
         count <= INIT_VAL;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/spio_hss_multiplexer_link_supervisor.sv
// Link-level sequencer for one HSS transceiver: RX reset, reset-done, byte
// sync and handshake, each step bounded by a timeout, with exponential
// backoff between attempts and sync-loss / handshake-drop tracking while up.
// Optional counters are built when SPIO_HSS_LINK_SUPERVISOR_STATS_EN is
// defined.
module spio_hss_multiplexer_link_supervisor
   import spio_hss_multiplexer_link_supervisor_pkg::*;
#(
   parameter int TIMER_BITS   = 24,
   parameter int RESET_CYCLES = 16,
   parameter int DONE_TIMEOUT = 65536,
   parameter int SYNC_TIMEOUT = 65536,
   parameter int HS_TIMEOUT   = 1048576,
   parameter int LOS_FILTER   = 8,
   parameter int BACKOFF_BASE = 1024
) (
   input  logic CLK_IN,
   input  logic RESET_IN,
   spio_hss_multiplexer_link_supervisor_if.master link
);

   localparam logic [TIMER_BITS-1:0] RESET_LOAD = TIMER_BITS'(RESET_CYCLES - 1);
   localparam logic [TIMER_BITS-1:0] DONE_LOAD  = TIMER_BITS'(DONE_TIMEOUT - 1);
   localparam logic [TIMER_BITS-1:0] SYNC_LOAD  = TIMER_BITS'(SYNC_TIMEOUT - 1);
   localparam logic [TIMER_BITS-1:0] HS_LOAD    = TIMER_BITS'(HS_TIMEOUT - 1);
   localparam logic [TIMER_BITS-1:0] LOS_LIMIT  = TIMER_BITS'(LOS_FILTER);
   localparam logic [63:0]           TIMER_CAP  = (64'd1 << TIMER_BITS) - 64'd1;
   localparam logic [3:0]            EXP_CAP    = 4'(MAX_BACKOFF_EXP);

   lsup_state_t           state_q, state_d;
   logic                  timer_load;
   logic [TIMER_BITS-1:0] timer_val;
   logic                  timer_zero;
   logic [TIMER_BITS-1:0] los_q, los_d, los_inc;
   logic [3:0]            retry_q, retry_d;
   logic                  verr_q, verr_d;
   logic                  fail;
   logic                  xrst_q, ctrl_q, up_q;

   // Backoff length doubles per failure up to the exponent cap and is
   // clipped to what the timer can hold.
   function automatic logic [TIMER_BITS-1:0] backoff_load(input logic [3:0] retry);
      logic [3:0]  shamt;
      logic [63:0] span;
      shamt = (retry > EXP_CAP) ? EXP_CAP : retry;
      span  = (64'(BACKOFF_BASE) << shamt) - 64'd1;
      return (span > TIMER_CAP) ? {TIMER_BITS{1'b1}} : span[TIMER_BITS-1:0];
   endfunction

   spio_hss_multiplexer_link_supervisor_timer #(
      .TIMER_BITS (TIMER_BITS),
      .INIT_VAL   (RESET_LOAD)
   ) u_timer (
      .CLK_IN   (CLK_IN),
      .RESET_IN (RESET_IN),
      .load     (timer_load),
      .load_val (timer_val),
      .zero     (timer_zero)
   );

   // Next-state, timer reload and bookkeeping; any failure funnels into one
   // common path that bumps the retry count and starts the backoff.
   always_comb begin
      state_d    = state_q;
      timer_load = 1'b0;
      timer_val  = '0;
      retry_d    = retry_q;
      verr_d     = verr_q;
      los_d      = '0;
      los_inc    = los_q + 1'b1;
      fail       = 1'b0;

      case (state_q)
         LSUP_XRESET: begin
            if (timer_zero) begin
               state_d    = LSUP_WAIT_DONE;
               timer_load = 1'b1;
               timer_val  = DONE_LOAD;
            end
         end
         LSUP_WAIT_DONE: begin
            if (link.XCVR_RESETDONE_IN) begin
               state_d    = LSUP_WAIT_SYNC;
               timer_load = 1'b1;
               timer_val  = SYNC_LOAD;
            end else if (timer_zero) begin
               fail = 1'b1;
            end
         end
         LSUP_WAIT_SYNC: begin
            if (link.RXLOSSOFSYNC_IN == 2'b00) begin
               state_d    = LSUP_HANDSHAKE;
               timer_load = 1'b1;
               timer_val  = HS_LOAD;
            end else if (timer_zero) begin
               fail = 1'b1;
            end
         end
         LSUP_HANDSHAKE: begin
            if (link.HANDSHAKE_COMPLETE_IN) begin
               state_d    = LSUP_UP;
               timer_load = 1'b1;
               retry_d    = 4'd0;
               verr_d     = 1'b0;
            end else if (link.VERSION_MISMATCH_IN) begin
               verr_d = 1'b1;
               fail   = 1'b1;
            end else if (timer_zero) begin
               fail = 1'b1;
            end
         end
         LSUP_UP: begin
            // Sync loss must persist LOS_FILTER cycles; it outranks a
            // handshake drop because it needs the full transceiver reset.
            if (link.RXLOSSOFSYNC_IN != 2'b00) begin
               los_d = los_inc;
            end
            if ((link.RXLOSSOFSYNC_IN != 2'b00) && (los_inc >= LOS_LIMIT)) begin
               fail = 1'b1;
            end else if (!link.HANDSHAKE_COMPLETE_IN) begin
               state_d    = LSUP_HANDSHAKE;
               timer_load = 1'b1;
               timer_val  = HS_LOAD;
            end
         end
         LSUP_BACKOFF: begin
            if (timer_zero) begin
               state_d    = LSUP_XRESET;
               timer_load = 1'b1;
               timer_val  = RESET_LOAD;
            end
         end
         default: begin
            state_d    = LSUP_XRESET;
            timer_load = 1'b1;
            timer_val  = RESET_LOAD;
         end
      endcase

      if (fail) begin
         state_d    = LSUP_BACKOFF;
         timer_load = 1'b1;
         timer_val  = backoff_load(retry_q);
         los_d      = '0;
         retry_d    = (retry_q == 4'd15) ? 4'd15 : retry_q + 4'd1;
      end
   end

   // State and outputs; outputs decode the next state so they move together.
   always_ff @(posedge CLK_IN or negedge RESET_IN) begin
      if (!RESET_IN) begin
         state_q <= LSUP_XRESET;
         los_q   <= '0;
         retry_q <= 4'd0;
         verr_q  <= 1'b0;
         xrst_q  <= 1'b1;
         ctrl_q  <= 1'b1;
         up_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         los_q   <= los_d;
         retry_q <= retry_d;
         verr_q  <= verr_d;
         xrst_q  <= (state_d == LSUP_XRESET);
         ctrl_q  <= (state_d inside {LSUP_XRESET, LSUP_WAIT_DONE,
                                     LSUP_WAIT_SYNC, LSUP_BACKOFF});
         up_q    <= (state_d == LSUP_UP);
      end
   end

   assign link.XCVR_RXRESET_OUT  = xrst_q;
   assign link.CTRL_RESET_OUT    = ctrl_q;
   assign link.LINK_UP_OUT       = up_q;
   assign link.STATE_OUT         = state_q;
   assign link.RETRY_COUNT_OUT   = retry_q;
   assign link.VERSION_ERROR_OUT = verr_q;

`ifdef SPIO_HSS_LINK_SUPERVISOR_STATS_EN
   logic        up_exit;
   logic        tmo_fail;
   logic [15:0] drops_q;
   logic [15:0] tmo_q;

   // A timeout failure is a fail taken on timer expiry, excluding the LOS
   // exit from UP and a version mismatch that outranks the expiry.
   assign up_exit  = (state_q == LSUP_UP) && (state_d != LSUP_UP);
   assign tmo_fail = fail && timer_zero && (state_q != LSUP_UP) &&
                     !((state_q == LSUP_HANDSHAKE) && link.VERSION_MISMATCH_IN);

   // Saturating event counters; a synchronous clear beats a same-cycle event.
   always_ff @(posedge CLK_IN or negedge RESET_IN) begin
      if (!RESET_IN) begin
         drops_q <= 16'd0;
         tmo_q   <= 16'd0;
      end else if (link.STATS_CLR_IN) begin
         drops_q <= 16'd0;
         tmo_q   <= 16'd0;
      end else begin
         if (up_exit && (drops_q != 16'hFFFF)) drops_q <= drops_q + 16'd1;
         if (tmo_fail && (tmo_q != 16'hFFFF))  tmo_q   <= tmo_q + 16'd1;
      end
   end

   assign link.LINK_DROPS_OUT = drops_q;
   assign link.TIMEOUTS_OUT   = tmo_q;
`endif

endmodule

// File: tb/tb_spio_hss_multiplexer_link_supervisor.sv
// Directed bench for the HSS link supervisor: a bring-up/up-state vector
// table plus hand-written sequences for backoff, handshake timeout, version
// mismatch and asynchronous reset.
module tb_spio_hss_multiplexer_link_supervisor;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   spio_hss_multiplexer_link_supervisor_if lif ();

   spio_hss_multiplexer_link_supervisor #(
      .TIMER_BITS   (24),
      .RESET_CYCLES (4),
      .DONE_TIMEOUT (32),
      .SYNC_TIMEOUT (32),
      .HS_TIMEOUT   (32),
      .LOS_FILTER   (3),
      .BACKOFF_BASE (8)
   ) dut (
      .CLK_IN   (clk),
      .RESET_IN (rst_n),
      .link     (lif)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         rep;
      logic       done;
      logic [1:0] los;
      logic       hs;
      logic       mm;
      logic [2:0] st;
      logic       xrst;
      logic       ctrl;
      logic       up;
      logic [3:0] retry;
      logic       verr;
   } vec_t;

   vec_t vecs[$];
   int   bo_tab[8] = '{8, 16, 32, 64, 128, 256, 512, 512};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic done, input logic [1:0] los, input logic hs, input logic mm);
      lif.XCVR_RESETDONE_IN     = done;
      lif.RXLOSSOFSYNC_IN       = los;
      lif.HANDSHAKE_COMPLETE_IN = hs;
      lif.VERSION_MISMATCH_IN   = mm;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_outs(input string tag, input logic [2:0] st, input logic xrst,
                             input logic ctrl, input logic up, input logic [3:0] retry,
                             input logic verr);
      check({tag, ".state"}, 32'(lif.STATE_OUT), 32'(st));
      check({tag, ".xrst"},  32'(lif.XCVR_RXRESET_OUT), 32'(xrst));
      check({tag, ".ctrl"},  32'(lif.CTRL_RESET_OUT), 32'(ctrl));
      check({tag, ".up"},    32'(lif.LINK_UP_OUT), 32'(up));
      check({tag, ".retry"}, 32'(lif.RETRY_COUNT_OUT), 32'(retry));
      check({tag, ".verr"},  32'(lif.VERSION_ERROR_OUT), 32'(verr));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Bounded wait until STATE_OUT equals s, sampled on falling edges.
   task automatic wait_state(input string tag, input logic [2:0] s);
      int n;
      n = 0;
      while (lif.STATE_OUT != s && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".reach"}, 32'(lif.STATE_OUT), 32'(s));
   endtask

   // Count consecutive falling-edge samples in state s, bounded.
   task automatic count_state(input logic [2:0] s, output int n);
      n = 0;
      while (lif.STATE_OUT == s && n < 3000) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      drive(1'b0, 2'b11, 1'b0, 1'b0);
`ifdef SPIO_HSS_LINK_SUPERVISOR_STATS_EN
      lif.STATS_CLR_IN = 1'b0;
`endif

      // Bring-up and up-state vectors; each row is applied for rep edges.
      //            rep done los   hs  mm   st  x  c  u  r  v
      vecs.push_back('{3, 1'b0, 2'b11, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0});
      vecs.push_back('{1, 1'b0, 2'b11, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0});
      vecs.push_back('{5, 1'b0, 2'b11, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0});
      vecs.push_back('{1, 1'b1, 2'b11, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0});
      vecs.push_back('{1, 1'b1, 2'b11, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0});
      vecs.push_back('{1, 1'b1, 2'b00, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
      vecs.push_back('{7, 1'b1, 2'b00, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
      vecs.push_back('{1, 1'b1, 2'b00, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0});
      vecs.push_back('{1, 1'b1, 2'b00, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0});
      vecs.push_back('{2, 1'b1, 2'b01, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0});
      vecs.push_back('{1, 1'b1, 2'b00, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0});
      vecs.push_back('{1, 1'b1, 2'b00, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
      vecs.push_back('{4, 1'b1, 2'b00, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
      vecs.push_back('{1, 1'b1, 2'b00, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0});
      vecs.push_back('{2, 1'b1, 2'b01, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0});
      vecs.push_back('{1, 1'b1, 2'b01, 1'b1, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0});
      vecs.push_back('{7, 1'b1, 2'b00, 1'b1, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0});
      vecs.push_back('{1, 1'b1, 2'b00, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0});

      // Reset values while RESET_IN is held low
      @(negedge clk);
      @(negedge clk);
      check_outs("rst", 3'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      rst_n = 1'b1;

      // Table-driven bring-up, LOS filter and handshake drop
      for (int i = 0; i < vecs.size(); i++) begin
         for (int r = 0; r < vecs[i].rep; r++) begin
            drive(vecs[i].done, vecs[i].los, vecs[i].hs, vecs[i].mm);
            step();
            check_outs($sformatf("vec%0d_%0d", i, r), vecs[i].st, vecs[i].xrst,
                       vecs[i].ctrl, vecs[i].up, vecs[i].retry, vecs[i].verr);
         end
      end
`ifdef SPIO_HSS_LINK_SUPERVISOR_STATS_EN
      check("stats.drops", 32'(lif.LINK_DROPS_OUT), 32'd2);
      check("stats.tmo0",  32'(lif.TIMEOUTS_OUT), 32'd0);
`endif

      // RESETDONE never arrives: done timeout, doubling backoff, saturation
      drive(1'b0, 2'b11, 1'b0, 1'b0);
      do_reset();
      wait_state("bo_start", 3'd1);
      for (int k = 0; k < 16; k++) begin
         count_state(3'd1, n);
         check($sformatf("bo%0d.done_len", k), 32'(n), 32'd32);
         check($sformatf("bo%0d.retry", k), 32'(lif.RETRY_COUNT_OUT), (k < 15) ? 32'(k + 1) : 32'd15);
         count_state(3'd5, n);
         check($sformatf("bo%0d.len", k), 32'(n), 32'(bo_tab[(k < 7) ? k : 7]));
         check($sformatf("bo%0d.xrst", k), 32'(lif.XCVR_RXRESET_OUT), 32'd1);
         count_state(3'd0, n);
         check($sformatf("bo%0d.xrst_len", k), 32'(n), 32'd4);
      end
`ifdef SPIO_HSS_LINK_SUPERVISOR_STATS_EN
      check("stats.tmo16", 32'(lif.TIMEOUTS_OUT), 32'd16);
      lif.STATS_CLR_IN = 1'b1;
      step();
      lif.STATS_CLR_IN = 1'b0;
      check("stats.clr", 32'(lif.TIMEOUTS_OUT), 32'd0);
`endif

      // Handshake timeout: 32 cycles in HANDSHAKE then backoff
      drive(1'b1, 2'b00, 1'b0, 1'b0);
      do_reset();
      wait_state("hs_to", 3'd3);
      count_state(3'd3, n);
      check("hs_to.len", 32'(n), 32'd32);
      check_outs("hs_to.fail", 3'd5, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0);

      // Version mismatch: sticky across a retry, cleared on entry to UP
      do_reset();
      wait_state("vm1", 3'd3);
      drive(1'b1, 2'b00, 1'b0, 1'b1);
      step();
      check_outs("vm.fail", 3'd5, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1);
      drive(1'b1, 2'b00, 1'b0, 1'b0);
      wait_state("vm2", 3'd1);
      check("vm.sticky_wd", 32'(lif.VERSION_ERROR_OUT), 32'd1);
      wait_state("vm3", 3'd3);
      check("vm.sticky_hs", 32'(lif.VERSION_ERROR_OUT), 32'd1);
      drive(1'b1, 2'b00, 1'b1, 1'b1);
      step();
      check_outs("vm.both", 3'd4, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);

      // Asynchronous reset between clock edges while UP
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("async", 3'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("async.after", 32'(lif.STATE_OUT), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends with a summary line
   initial begin
      #2000000;
      bad++;
      $display("FAIL watchdog: got timeout want finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
